// File: rtl/agc_mem_sequencer_if.sv
// rtl/agc_mem_sequencer_if.sv - request/response and memory-port bundle for agc_mem_sequencer
// master = sequencer side; slave = control unit plus memory side.
interface agc_mem_sequencer_if #(
    parameter int AW = 12,
    parameter int DW = 15
);
    logic          req;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic          done;
    logic [DW-1:0] rdata;
    logic          err;
    logic          ovf;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_tp;
    logic [DW-1:0] mem_rdata;

    modport master (
        input  req, op, addr, wdata, mem_rdata,
        output ready, done, rdata, err, ovf, mem_addr, mem_wdata, mem_we, mem_tp
    );

    modport slave (
        output req, op, addr, wdata, mem_rdata,
        input  ready, done, rdata, err, ovf, mem_addr, mem_wdata, mem_we, mem_tp
    );
endinterface

// File: rtl/agc_mem_sequencer.sv
// rtl/agc_mem_sequencer.sv - AGC data-memory initiator: read/write/incr/decr sequencing
// Optional AGC_EDIT_REG_EN: WRITEs to 010..013 store the CYR/SR/CYL/EDOP-edited word.
module agc_mem_sequencer #(
    parameter int            AW            = 12,
    parameter int            DW            = 15,
    parameter logic [AW-1:0] ZERO_ADDR     = 'h007,
    parameter int            SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    agc_mem_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_FETCH, S_MODIFY, S_WSETUP, S_STORE, S_DONE
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_INCR  = 2'b10;
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] g_q, g_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          we_q, we_d;
    logic          tp_q, tp_d;
    logic [DW-1:0] opnd;
    logic [DW:0]   sum;
    logic [DW-1:0] res;
    logic          erasable, wr_ok;

    assign erasable = (addr_q[AW-1:AW-2] == 2'b00);
    assign wr_ok    = erasable && (addr_q != ZERO_ADDR);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        g_d     = g_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        we_d    = 1'b0;
        tp_d    = 1'b0;
        opnd    = '0;
        sum     = '0;
        res     = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    op_d    = bus.op;
                    addr_d  = bus.addr;
                    cnt_d   = CNT_INIT;
                    ovf_d   = 1'b0;
                    state_d = S_SETTLE;
                    if (bus.op == OP_WRITE) begin
`ifdef AGC_EDIT_REG_EN
                        case (bus.addr)
                            AW'('h010): g_d = {bus.wdata[0], bus.wdata[DW-1:1]};
                            AW'('h011): g_d = {bus.wdata[DW-1], bus.wdata[DW-1:1]};
                            AW'('h012): g_d = {bus.wdata[DW-2:0], bus.wdata[DW-1]};
                            AW'('h013): g_d = {8'b0, bus.wdata[13:7]};
                            default:    g_d = bus.wdata;
                        endcase
`else
                        g_d = bus.wdata;
`endif
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) state_d = (op_q == OP_WRITE) ? S_WSETUP : S_FETCH;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_FETCH: begin
                g_d     = bus.mem_rdata;
                state_d = (op_q == OP_READ) ? S_DONE : S_MODIFY;
            end
            S_MODIFY: begin
                // Ones'-complement add: -1 is 7FFE, carry out of bit 14 wraps into bit 0.
                opnd    = (op_q == OP_INCR) ? DW'(1) : {{(DW-1){1'b1}}, 1'b0};
                sum     = {1'b0, g_q} + {1'b0, opnd};
                res     = sum[DW-1:0] + {{(DW-1){1'b0}}, sum[DW]};
                g_d     = res;
                ovf_d   = (g_q[DW-1] == opnd[DW-1]) && (res[DW-1] != g_q[DW-1]);
                state_d = S_WSETUP;
            end
            S_WSETUP: state_d = S_STORE;
            S_STORE:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Registered strobes: we spans WSETUP+STORE so tp rises only after we/data settle.
        if ((state_d == S_WSETUP) || (state_d == S_STORE)) we_d = wr_ok;
        tp_d = (state_d == S_STORE);
        if (state_d == S_DONE) begin
            done_d  = 1'b1;
            rdata_d = g_d;
            err_d   = (op_q != OP_READ) && !erasable;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            g_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            tp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            g_q     <= g_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            tp_q    <= tp_d;
        end
    end

    assign bus.ready     = (state_q == S_IDLE);
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;
    assign bus.ovf       = ovf_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = g_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_tp    = tp_q;
endmodule

// File: tb/tb_agc_mem_sequencer.sv
// tb/tb_agc_mem_sequencer.sv - self-checking bench for agc_mem_sequencer (AGC_EDIT_REG_EN aware)
module tb_agc_mem_sequencer;
    localparam int AW = 12;
    localparam int DW = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    agc_mem_sequencer_if #(.AW(AW), .DW(DW)) bus ();

    agc_mem_sequencer #(
        .AW(AW), .DW(DW), .ZERO_ADDR(12'h007), .SETTLE_CYCLES(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    logic [DW-1:0] mem     [0:4095];
    logic [DW-1:0] exp_mem [0:4095];
    logic          pl_en   = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en)                          mem[pl_addr]      <= pl_data;
        else if (bus.mem_tp && bus.mem_we)  mem[bus.mem_addr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    int we_cyc = 0;
    int tp_cyc = 0;
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) we_cyc++;
        if (bus.mem_tp === 1'b1) tp_cyc++;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oc_val(input logic [14:0] w);
        logic [14:0] n;
        n = ~w;
        return w[14] ? -int'(n) : int'(w);
    endfunction

    function automatic logic [14:0] oc_enc(input int v);
        logic [14:0] m;
        if (v > 0) return 15'(v);
        m = 15'(-v);
        return ~m;
    endfunction

    function automatic logic [14:0] edit_model(input logic [11:0] a, input logic [14:0] w);
        logic [14:0] r;
        r = w;
`ifdef AGC_EDIT_REG_EN
        case (a)
            12'h010: r = {w[0], w[14:1]};
            12'h011: r = {w[14], w[14:1]};
            12'h012: r = {w[13:0], w[14]};
            12'h013: r = {8'b0, w[13:7]};
            default: r = w;
        endcase
`else
        if (a == 12'hFFF) r = w;
`endif
        return r;
    endfunction

    task automatic preload(input logic [11:0] a, input logic [14:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [11:0] a, input logic [14:0] wd, input bit hold);
        logic [14:0] exp_r;
        bit          exp_err, exp_ovf, wok;
        int          exp_lat, exp_we, cyc, we0, tp0, v;
        wok     = (a[11:10] == 2'b00) && (a != 12'h007);
        exp_err = (op != 2'b00) && (a[11:10] != 2'b00);
        exp_ovf = 1'b0;
        case (op)
            2'b00: begin exp_r = exp_mem[a]; exp_lat = 3; end
            2'b01: begin exp_r = edit_model(a, wd); exp_lat = 4; end
            default: begin
                v = oc_val(exp_mem[a]) + ((op == 2'b10) ? 1 : -1);
                if (v > 16383)       begin v -= 32767; exp_ovf = 1'b1; end
                else if (v < -16383) begin v += 32767; exp_ovf = 1'b1; end
                exp_r   = oc_enc(v);
                exp_lat = 6;
            end
        endcase
        exp_we = (op != 2'b00 && wok) ? 2 : 0;
        if (op != 2'b00 && wok) exp_mem[a] = exp_r;

        check("ready_idle", {31'b0, bus.ready}, 32'd1);
        bus.req = 1'b1; bus.op = op; bus.addr = a; bus.wdata = wd;
        @(posedge clk); #1;
        if (!hold) bus.req = 1'b0;
        we0 = we_cyc; tp0 = tp_cyc; cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        bus.req = 1'b0;
        check($sformatf("latency op%0d a%0h", op, a), cyc, exp_lat);
        check($sformatf("rdata op%0d a%0h", op, a), {17'b0, bus.rdata}, {17'b0, exp_r});
        check($sformatf("err op%0d a%0h", op, a), {31'b0, bus.err}, {31'b0, exp_err});
        check($sformatf("ovf op%0d a%0h", op, a), {31'b0, bus.ovf}, {31'b0, exp_ovf});
        check($sformatf("we_cycles op%0d a%0h", op, a), we_cyc - we0, exp_we);
        check($sformatf("tp_pulses op%0d a%0h", op, a), tp_cyc - tp0, (op != 2'b00) ? 1 : 0);
        check($sformatf("mem a%0h", a), {17'b0, mem[a]}, {17'b0, exp_mem[a]});
        @(posedge clk); #1;
        check("done_one_cycle", {31'b0, bus.done}, 32'd0);
    endtask

    logic [11:0] pool [10] = '{12'h005, 12'h007, 12'h020, 12'h030, 12'h031,
                               12'h032, 12'h3FF, 12'h400, 12'h7FF, 12'h021};

    initial begin
        int cyc;
        bus.req = 1'b0; bus.op = 2'b00; bus.addr = '0; bus.wdata = '0;

        preload(12'h005, 15'h1234);
        preload(12'h007, 15'h0000);
        preload(12'h020, 15'h0000);
        preload(12'h021, 15'h5555);
        preload(12'h030, 15'h7FFF);
        preload(12'h031, 15'h3FFF);
        preload(12'h032, 15'h4000);
        preload(12'h3FF, 15'($urandom));
        preload(12'h400, 15'h2222);
        preload(12'h7FF, 15'($urandom));
        preload(12'h010, 15'h0000);
        preload(12'h013, 15'h0000);

        check("rst_ready",  {31'b0, bus.ready},  32'd1);
        check("rst_done",   {31'b0, bus.done},   32'd0);
        check("rst_we",     {31'b0, bus.mem_we}, 32'd0);
        check("rst_tp",     {31'b0, bus.mem_tp}, 32'd0);
        check("rst_rdata",  {17'b0, bus.rdata},  32'd0);
        check("rst_maddr",  {20'b0, bus.mem_addr}, 32'd0);
        check("rst_err_ovf", {30'b0, bus.err, bus.ovf}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'b00, 12'h005, 15'h0000, 1'b0);
        run_op(2'b01, 12'h020, 15'h0ABC, 1'b0);
        run_op(2'b01, 12'h007, 15'h1111, 1'b0);
        run_op(2'b01, 12'h400, 15'h1111, 1'b0);
        run_op(2'b10, 12'h030, 15'h0000, 1'b0);
        run_op(2'b10, 12'h031, 15'h0000, 1'b0);
        run_op(2'b11, 12'h032, 15'h0000, 1'b0);
        run_op(2'b00, 12'h020, 15'h0000, 1'b1);
        run_op(2'b10, 12'h400, 15'h0000, 1'b0);
        run_op(2'b01, 12'h010, 15'h0001, 1'b0);
        run_op(2'b01, 12'h013, 15'h7F80, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), pool[$urandom_range(0, 9)],
                   15'($urandom), bit'($urandom_range(0, 1)));
        end

        bus.req = 1'b1; bus.op = 2'b01; bus.addr = 12'h021; bus.wdata = 15'h0F0F;
        @(posedge clk); #1;
        bus.req = 1'b0;
        cyc = 0;
        while (bus.mem_tp !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("tp_reached", {31'b0, bus.mem_tp}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_tp",   {31'b0, bus.mem_tp}, 32'd0);
        check("rst_mid_we",   {31'b0, bus.mem_we}, 32'd0);
        check("rst_mid_done", {31'b0, bus.done},   32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_mid_no_done", {31'b0, bus.done}, 32'd0);
        check("rst_mid_ready",   {31'b0, bus.ready}, 32'd1);
        exp_mem[12'h021] = mem[12'h021];
        @(posedge clk); #1;
        run_op(2'b00, 12'h005, 15'h0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
